// File: rtl/fwrisc_mds_arbiter.sv
// Two-port arbiter sharing one multi-cycle multiply/divide/shift unit.
// Optional WAIT-state watchdog enabled by defining FWRISC_MDS_ARB_TIMEOUT_EN.
module fwrisc_mds_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,

  output logic [31:0] mds_in_a,
  output logic [31:0] mds_in_b,
  output logic [3:0]  mds_op,
  output logic        mds_in_valid,
  input  logic [31:0] mds_out,
  input  logic        mds_out_valid,

  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_MAX = 4'd8;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("fwrisc_mds_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  state_t      r_state;
  state_t      w_state_next;

  logic        r_ptr;
  logic        r_owner;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_op;
  logic [31:0] r_data;
  logic        r_err;

  logic        w_any_req;
  logic        w_gnt_port;
  logic        w_req_hs;
  logic        w_rsp_hs;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic [3:0]  w_sel_op;
  logic        w_op_illegal;
  logic        w_timeout;

  // Grant selection: the pointer only matters when both ports contend.
  always_comb begin
    w_any_req  = req0_valid | req1_valid;
    w_gnt_port = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_port = (ROUND_ROBIN != 0) ? r_ptr : 1'b0;
    end else begin
      w_gnt_port = req1_valid;
    end
  end

  always_comb begin
    w_sel_a      = w_gnt_port ? req1_a  : req0_a;
    w_sel_b      = w_gnt_port ? req1_b  : req0_b;
    w_sel_op     = w_gnt_port ? req1_op : req0_op;
    w_op_illegal = (w_sel_op > OP_MAX);
  end

  assign w_req_hs = (r_state == S_IDLE) && w_any_req;
  assign w_rsp_hs = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);

`ifdef FWRISC_MDS_ARB_TIMEOUT_EN
  localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] r_wdog;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wdog == WDOG_LIMIT);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    mds_in_valid = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy       = 1'b0;
        req0_ready = w_req_hs && !w_gnt_port;
        req1_ready = w_req_hs &&  w_gnt_port;
        if (w_req_hs) begin
          w_state_next = w_op_illegal ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mds_in_valid = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // A result in the limit cycle still counts as a normal completion.
        if (mds_out_valid || w_timeout) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp0_valid = !r_owner;
        rsp1_valid =  r_owner;
        if (w_rsp_hs) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_owner <= w_gnt_port;
            if (w_op_illegal) begin
              r_data <= '0;
              r_err  <= 1'b1;
            end else begin
              // Operands feed the unit directly, so they only move on a real issue.
              r_a  <= w_sel_a;
              r_b  <= w_sel_b;
              r_op <= w_sel_op;
            end
          end
        end
        S_WAIT: begin
          if (mds_out_valid) begin
            r_data <= mds_out;
            r_err  <= 1'b0;
          end else if (w_timeout) begin
            r_data <= '0;
            r_err  <= 1'b1;
          end
        end
        S_RESP: begin
          if (w_rsp_hs && (ROUND_ROBIN != 0)) begin
            r_ptr <= ~r_owner;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mds_in_a  = r_a;
  assign mds_in_b  = r_b;
  assign mds_op    = r_op;

  // Each port only sees the result it owns; the other reads zero.
  assign rsp0_data = r_owner ? 32'h0 : r_data;
  assign rsp0_err  = r_owner ? 1'b0  : r_err;
  assign rsp1_data = r_owner ? r_data : 32'h0;
  assign rsp1_err  = r_owner ? r_err  : 1'b0;

endmodule

// File: tb/tb_fwrisc_mds_arbiter.sv
// Self-checking bench for fwrisc_mds_arbiter: vector table plus directed corner sequences.
module tb_fwrisc_mds_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic [31:0] mds_in_a, mds_in_b, mds_out;
  logic [3:0]  mds_op;
  logic        mds_in_valid, mds_out_valid, busy;

  fwrisc_mds_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .mds_in_a(mds_in_a), .mds_in_b(mds_in_b), .mds_op(mds_op), .mds_in_valid(mds_in_valid),
    .mds_out(mds_out), .mds_out_valid(mds_out_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  int ncyc = 0;
  always @(negedge clock) ncyc <= ncyc + 1;

  // Behavioural unit: result appears L cycles after the issue cycle.
  int unsigned lat = 3;
  logic        hang = 1'b0;
  logic        spur = 1'b0;
  int unsigned m_cnt = 0;
  logic [31:0] m_res = '0;
  int          issue_cnt = 0;
  logic [31:0] seen_a = '0, seen_b = '0;
  logic [3:0]  seen_op = '0;

  function automatic logic [31:0] unit_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu;
    logic signed [63:0] ps;
    pu = {32'h0, a} * {32'h0, b};
    ps = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    case (op)
      4'd0: return a << b[4:0];
      4'd1: return a >> b[4:0];
      4'd2: return $unsigned($signed(a) >>> b[4:0]);
      4'd3: return pu[31:0];
      4'd4: return pu[63:32];
      4'd5: return ps[31:0];
      4'd6: return ps[63:32];
      4'd7: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd8: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (mds_in_valid) begin
      issue_cnt <= issue_cnt + 1;
      seen_a    <= mds_in_a;
      seen_b    <= mds_in_b;
      seen_op   <= mds_op;
      m_res     <= unit_calc(mds_op, mds_in_a, mds_in_b);
      if (!hang) m_cnt <= lat;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign mds_out_valid = (m_cnt == 1) | spur;
  assign mds_out       = spur ? 32'hDEAD_BEEF : m_res;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return p != 0 ? req1_ready : req0_ready;
  endfunction
  function automatic logic rv(input int p);
    return p != 0 ? rsp1_valid : rsp0_valid;
  endfunction
  function automatic logic [31:0] rd(input int p);
    return p != 0 ? rsp1_data : rsp0_data;
  endfunction
  function automatic logic re(input int p);
    return p != 0 ? rsp1_err : rsp0_err;
  endfunction

  task automatic set_req(input int p, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p != 0) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int t_acc);
    bit got;
    got = 0;
    t_acc = 0;
    set_req(p, 1'b1, op, a, b);
    for (int i = 0; i < 300 && !got; i++) begin
      #1;
      if (rdy(p)) begin
        got = 1;
        t_acc = ncyc;
      end
      @(negedge clock);
    end
    set_req(p, 1'b0, op, a, b);
    chk("req_accept_seen", {31'h0, got}, 32'h1);
  endtask

  // Returns 1 time unit after the falling edge on which rsp_valid is seen.
  task automatic wait_rsp(input int p, output int t_rsp);
    bit got;
    got = 0;
    t_rsp = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      #1;
      if (rv(p)) begin
        got = 1;
        t_rsp = ncyc;
      end else begin
        @(negedge clock);
      end
    end
    chk("rsp_valid_seen", {31'h0, got}, 32'h1);
  endtask

  task automatic accept(input int p);
    if (p != 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clock);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int t0, t1, ic0;
    bit bad;

    vecs[0]  = '{0, 4'd0, 32'h0000_0001, 32'd4, 32'h0000_0010, 1'b0};
    vecs[1]  = '{1, 4'd1, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0};
    vecs[2]  = '{0, 4'd2, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0};
    vecs[3]  = '{1, 4'd3, 32'd7,         32'd6, 32'd42,        1'b0};
    vecs[4]  = '{0, 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[5]  = '{1, 4'd5, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b0};
    vecs[6]  = '{0, 4'd6, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{1, 4'd7, 32'd100,       32'd7, 32'd14,        1'b0};
    vecs[8]  = '{0, 4'd8, 32'd100,       32'd7, 32'd2,         1'b0};
    vecs[9]  = '{1, 4'd12, 32'h1234_5678, 32'd9, 32'h0,        1'b1};
    vecs[10] = '{0, 4'd9, 32'hAAAA_5555, 32'd1, 32'h0,         1'b1};

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("reset_ctrl", {26'h0, busy, rsp0_valid, rsp1_valid, mds_in_valid, rsp0_err, rsp1_err}, 32'h0);
    chk("reset_data", rsp0_data | rsp1_data | mds_in_a | mds_in_b | {28'h0, mds_op}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Round robin: simultaneous requests after reset go to port 0 first
    @(negedge clock);
    set_req(0, 1'b1, 4'd7, 32'd100, 32'd7);
    set_req(1, 1'b1, 4'd0, 32'd1, 32'd4);
    #1;
    chk("rr_first_p0_ready", {30'h0, req1_ready, req0_ready}, 32'h1);
    @(negedge clock);
    set_req(0, 1'b0, 4'd0, 32'h0, 32'h0);
    #1;
    chk("rr_p1_pending_ready", {31'h0, req1_ready}, 32'h0);
    wait_rsp(0, t1);
    chk("rr_p0_div_data", rsp0_data, 32'd14);
    $display("txn rr port=0 DIV data=%0d err=%0d", rsp0_data, rsp0_err);
    accept(0);
    // Port 0 re-requests at once; pointer now favours port 1
    set_req(0, 1'b1, 4'd8, 32'd100, 32'd7);
    #1;
    chk("rr_second_p1_ready", {30'h0, req1_ready, req0_ready}, 32'h2);
    @(negedge clock);
    set_req(1, 1'b0, 4'd0, 32'h0, 32'h0);
    wait_rsp(1, t1);
    chk("rr_p1_sll_data", rsp1_data, 32'd16);
    $display("txn rr port=1 SLL data=%0d err=%0d", rsp1_data, rsp1_err);
    accept(1);
    #1;
    chk("rr_third_p0_ready", {30'h0, req1_ready, req0_ready}, 32'h1);
    @(negedge clock);
    set_req(0, 1'b0, 4'd0, 32'h0, 32'h0);
    set_req(1, 1'b1, 4'd0, 32'd1, 32'd4);

    // REM result held while the requester stalls; port 1 stays blocked
    wait_rsp(0, t1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp0_data !== 32'd2 || rsp0_valid !== 1'b1 || req1_ready !== 1'b0 || rsp0_err !== 1'b0) bad = 1;
      @(negedge clock);
      #1;
    end
    chk("hold_rem_stable", {31'h0, bad}, 32'h0);
    chk("hold_rem_data", rsp0_data, 32'd2);
    $display("txn hold port=0 REM data=%0d err=%0d", rsp0_data, rsp0_err);
    accept(0);
    #1;
    chk("hold_idle_after_hs", {30'h0, busy, req1_ready}, 32'h1);
    @(negedge clock);
    set_req(1, 1'b0, 4'd0, 32'h0, 32'h0);
    wait_rsp(1, t1);
    chk("hold_p1_data", rsp1_data, 32'd16);
    accept(1);

    // Table-driven single transactions
    lat = 3;
    for (int k = 0; k < 11; k++) begin
      ic0 = issue_cnt;
      send(vecs[k].port, vecs[k].op, vecs[k].a, vecs[k].b, t0);
      wait_rsp(vecs[k].port, t1);
      chk($sformatf("v%0d_data", k), rd(vecs[k].port), vecs[k].exp_data);
      chk($sformatf("v%0d_err", k), {31'h0, re(vecs[k].port)}, {31'h0, vecs[k].exp_err});
      chk($sformatf("v%0d_lat", k), t1 - t0, vecs[k].exp_err ? 32'd1 : 32'(lat + 2));
      chk($sformatf("v%0d_other_rsp", k), {31'h0, rv(1 - vecs[k].port)}, 32'h0);
      if (vecs[k].exp_err) begin
        chk($sformatf("v%0d_no_issue", k), issue_cnt - ic0, 32'd0);
      end else begin
        chk($sformatf("v%0d_issued", k), {seen_op, seen_a ^ seen_b}, {vecs[k].op, vecs[k].a ^ vecs[k].b});
      end
      $display("txn v%0d port=%0d op=%0d data=%h err=%0d lat=%0d", k, vecs[k].port, vecs[k].op,
               rd(vecs[k].port), re(vecs[k].port), t1 - t0);
      accept(vecs[k].port);
    end

    // MUL with a 33-cycle unit
    lat = 33;
    send(0, 4'd3, 32'd7, 32'd6, t0);
    #1;
    chk("mul_issue_pulse", {31'h0, mds_in_valid}, 32'h1);
    chk("mul_issue_ops", {mds_op, mds_in_a[27:0]}, {4'd3, 28'd7});
    chk("mul_issue_b", mds_in_b, 32'd6);
    @(negedge clock);
    #1;
    chk("mul_issue_single", {31'h0, mds_in_valid}, 32'h0);
    wait_rsp(0, t1);
    chk("mul_latency", t1 - t0, 32'd35);
    chk("mul_data", rsp0_data, 32'd42);
    chk("mul_err_rsp1", {30'h0, rsp0_err, rsp1_valid}, 32'h0);
    $display("txn mul port=0 data=%0d err=%0d lat=%0d", rsp0_data, rsp0_err, t1 - t0);
    accept(0);

    // Spurious unit result while idle is dropped
    spur = 1'b1;
    @(negedge clock);
    spur = 1'b0;
    #1;
    chk("spurious_ignored", {29'h0, busy, rsp0_valid, rsp1_valid}, 32'h0);

    // Reset in WAIT; the late unit result must not resurrect anything
    lat = 6;
    @(negedge clock);
    send(0, 4'd3, 32'd3, 32'd5, t0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_wait_ctrl", {26'h0, busy, rsp0_valid, rsp1_valid, mds_in_valid, rsp0_err, rsp1_err}, 32'h0);
    chk("rst_wait_data", rsp0_data | mds_in_a | mds_in_b | {28'h0, mds_op}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (busy || rsp0_valid || rsp1_valid) bad = 1;
      @(negedge clock);
    end
    chk("rst_late_result_dropped", {31'h0, bad}, 32'h0);

    // Unit that never answers
    hang = 1'b1;
`ifdef FWRISC_MDS_ARB_TIMEOUT_EN
    send(0, 4'd3, 32'd9, 32'd9, t0);
    wait_rsp(0, t1);
    chk("timeout_latency", t1 - t0, 32'd10);
    chk("timeout_err", {31'h0, rsp0_err}, 32'h1);
    chk("timeout_data", rsp0_data, 32'h0);
    $display("txn timeout port=0 data=%h err=%0d lat=%0d", rsp0_data, rsp0_err, t1 - t0);
    accept(0);
    #1;
    chk("timeout_idle", {31'h0, busy}, 32'h0);
`else
    send(0, 4'd3, 32'd9, 32'd9, t0);
    repeat (40) @(negedge clock);
    #1;
    chk("no_timeout_still_busy", {30'h0, busy, rsp0_valid}, 32'h2);
    $display("txn hang port=0 busy=%0d rsp_valid=%0d", busy, rsp0_valid);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
`endif
    hang = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule

// File: doc/fwrisc_mds_arbiter.md
Name: fwrisc_mds_arbiter

Overview:
Shares one multi-cycle multiply/divide/shift unit between two requesters: port 0 is the integer pipeline and port 1 is the auxiliary/debug path.
Arbitrates requests, issues exactly one operation at a time to the unit as a single-cycle in_valid pulse, and waits for its out_valid.
Holds each result on the owning requester's response channel until that requester accepts it.
Rejects illegal op codes locally, without engaging the unit.

Parameters:
ROUND_ROBIN, 1, 1 = priority pointer alternates after each completed response; 0 = port 0 always wins
TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only when the optional feature is enabled; must be >= 2

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_a  in  32  port 0 operand A
req0_b  in  32  port 0 operand B
req0_op  in  4  port 0 op code (0=SLL, 1=SRL, 2=SRA, 3=MUL, 4=MULH, 5=MULS, 6=MULSH, 7=DIV, 8=REM)
rsp0_valid  out  1  port 0 response valid
rsp0_ready  in  1  port 0 response accept
rsp0_data  out  32  port 0 result
rsp0_err  out  1  port 0 error flag (illegal op or timeout)
req1_*/rsp1_*  same set, widths and meanings as port 0
mds_in_a  out  32  operand A to the unit
mds_in_b  out  32  operand B to the unit
mds_op  out  4  op code to the unit
mds_in_valid  out  1  single-cycle issue pulse
mds_out  in  32  unit result
mds_out_valid  in  1  unit result valid pulse
busy  out  1  high in every state other than IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, priority pointer=0, owner=0.
  - All outputs 0, including the operand, data and error registers.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the single valid port.
  - If both ports are valid, grant goes to the pointer port (ROUND_ROBIN=1) or to port 0 (ROUND_ROBIN=0).
  - reqN_ready is combinational: 1 only for the granted port, only in IDLE.
  - On the handshake, capture a, b, op and owner.
  - op <= 8: go to ISSUE.
  - op > 8: go to RESP with err=1, data=0; mds_in_valid is never asserted.
- ISSUE (1 cycle):
  - mds_in_valid=1; mds_in_a, mds_in_b, mds_op driven from the captured registers.
  - Go to WAIT.
  - The operand outputs hold their values until the next issue.
- WAIT:
  - On mds_out_valid=1, capture mds_out into the response data register, set err=0, go to RESP.
- RESP:
  - rspN_valid=1 for the owner only; data and err stay stable until rspN_ready=1.
  - On the handshake: go to IDLE next cycle; if ROUND_ROBIN=1, pointer = ~owner.
  - rspN_ready while rspN_valid=0 is ignored.
- Latency:
  - Request accepted at cycle T, mds_in_valid at T+1.
  - If out_valid arrives at T+1+L, rsp_valid is asserted at T+2+L.
  - Illegal op: rsp_valid at T+1.
  - Minimum gap from a response handshake to the next request acceptance: 1 cycle.
- mds_out_valid outside WAIT (stale or spurious) is discarded; state does not change.
- A request that arrives while busy stays pending, with ready=0; requesters must hold valid and payload stable until ready.
- reset_n asserted in any state gives an immediate return to reset values; any in-flight result is later discarded per the rule above.
- No starvation: with ROUND_ROBIN=1 and both ports continuously valid, grants alternate 0,1,0,1.

Optional Feature:
FWRISC_MDS_ARB_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 without mds_out_valid: go to RESP with err=1, data=32'h0.
  - Any late out_valid is discarded.
  - mds_out_valid in the same cycle as the limit wins: normal result, err=0.
- Undefined: no counter; WAIT lasts indefinitely; err=1 only for illegal ops.

Test Plan:
- Port 0 MUL, a=7, b=6; unit model with L=33 -> mds_in_valid one cycle, rsp0_valid with data=42, err=0, at T+35; rsp1_valid stays 0.
- Both ports valid after reset: port 0 DIV 100/7, port 1 SLL 1<<4 -> port 0 granted first (rsp0_data=14); port 1 then gets data=16; next simultaneous pair is granted to port 1 first.
- Port 1 op=4'd12 -> rsp1_valid at T+1 with err=1, data=0; mds_in_valid never asserted.
- Hold rsp0_ready=0 for 5 cycles after a REM 100%7 -> rsp0_data=2 stable throughout; req1_ready=0 throughout; after the handshake, IDLE on the next cycle.
- reset_n low for 1 cycle during WAIT, then unit out_valid 3 cycles later -> all outputs 0, busy=0, no rsp_valid.
- With the macro defined, TIMEOUT_CYCLES=8, and a unit that never responds -> rsp0_valid with err=1, data=0 after 8 WAIT cycles.
